// File: rtl/sprite_evaluator.sv
// rtl/sprite_evaluator.sv - per-scanline sprite evaluation: clears secondary OAM,
// scans 64 primary sprites for Y hits, copies up to 8 and flags overflow / sprite zero.
module sprite_evaluator #(
   parameter int VISIBLE_LINES  = 240,
   parameter int PRERENDER_LINE = 261
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clock_EN,
   input  logic       render_EN,
   input  logic       sprite_size_16,
   input  logic [8:0] scanline,
   input  logic [8:0] dot,
   output logic [7:0] oam_address,
   input  logic [7:0] oam_data,
   output logic       sec_write,
   output logic [4:0] sec_address,
   output logic [7:0] sec_dataIn,
   output logic [3:0] sprite_count,
   output logic       sprite_zero_next,
   output logic       sprite_overflow
);

   localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
   localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

   typedef enum logic [2:0] {IDLE, CLEAR, EVAL_Y, COPY, FULL_SCAN, DONE} state_t;

   state_t     state, state_next;
   logic [5:0] n, n_next;
   logic [1:0] m, m_next;
   logic [3:0] count, count_next;
   logic       zero_d, ovf_d;

   logic       active;
   logic [9:0] diff, height;
   logic       in_range;

   assign active   = render_EN && (scanline < VIS_LINES);
   assign diff     = {1'b0, scanline} - {2'b00, oam_data};
   assign height   = sprite_size_16 ? 10'd16 : 10'd8;
   assign in_range = !diff[9] && (diff < height);

   assign sprite_count = count;

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         n                <= '0;
         m                <= '0;
         count            <= '0;
         sprite_zero_next <= 1'b0;
         sprite_overflow  <= 1'b0;
      end else if (clock_EN) begin
         state            <= state_next;
         n                <= n_next;
         m                <= m_next;
         count            <= count_next;
         sprite_zero_next <= zero_d;
         sprite_overflow  <= ovf_d;
      end
   end

   always_comb begin
      state_next  = state;
      n_next      = n;
      m_next      = m;
      count_next  = count;
      zero_d      = sprite_zero_next;
      ovf_d       = sprite_overflow;
      oam_address = '0;
      sec_write   = 1'b0;
      sec_address = '0;
      sec_dataIn  = '0;

      case (state)
         CLEAR: begin
            // Dots 1..32 fill secondary OAM with FF; 33..64 wait for the scan start.
            if (dot >= 9'd1 && dot <= 9'd32) begin
               sec_write   = 1'b1;
               sec_address = 5'(dot - 9'd1);
               sec_dataIn  = 8'hFF;
            end
            if (dot == 9'd64) begin
               state_next = EVAL_Y;
               n_next     = '0;
               m_next     = '0;
               count_next = '0;
               zero_d     = 1'b0;
            end
         end
         EVAL_Y: begin
            oam_address = {n, 2'b00};
            if (in_range) begin
               sec_write   = 1'b1;
               sec_address = {count[2:0], 2'b00};
               sec_dataIn  = oam_data;
               if (n == 6'd0) zero_d = 1'b1;
               m_next     = 2'd1;
               state_next = COPY;
            end else begin
               n_next = n + 6'd1;
               if (n == 6'd63) state_next = DONE;
            end
         end
         COPY: begin
            oam_address = {n, m};
            sec_write   = 1'b1;
            sec_address = {count[2:0], m};
            sec_dataIn  = oam_data;
            m_next      = m + 2'd1;
            if (m == 2'd3) begin
               count_next = count + 4'd1;
               n_next     = n + 6'd1;
               // After sprite 63 there is no ninth candidate, so never enter the overflow scan.
               if (n == 6'd63)
                  state_next = DONE;
               else if (count == 4'd7)
                  state_next = FULL_SCAN;
               else
                  state_next = EVAL_Y;
            end
         end
         FULL_SCAN: begin
            oam_address = {n, 2'b00};
            if (in_range) begin
               ovf_d      = 1'b1;
               state_next = DONE;
            end else begin
               n_next = n + 6'd1;
               if (n == 6'd63) state_next = DONE;
            end
         end
         default: ;
      endcase

      // Truncation at dot 257 or a mid-line render disable freezes results and blocks writes.
      if (state != IDLE && (!active || dot == 9'd257)) begin
         state_next = active ? DONE : IDLE;
         n_next     = n;
         m_next     = m;
         count_next = count;
         zero_d     = sprite_zero_next;
         ovf_d      = sprite_overflow;
         sec_write  = 1'b0;
      end

      if (active && dot == 9'd0) state_next = CLEAR;

      if (scanline == PRE_LINE && dot == 9'd1) ovf_d = 1'b0;
   end

endmodule

// File: tb/tb_sprite_evaluator.sv
// tb/tb_sprite_evaluator.sv - directed bench for sprite_evaluator with OAM models.
module tb_sprite_evaluator;

   logic       clock;
   logic       reset;
   logic       clock_EN;
   logic       render_EN;
   logic       sprite_size_16;
   logic [8:0] scanline;
   logic [8:0] dot;
   logic [7:0] oam_address;
   logic [7:0] oam_data;
   logic       sec_write;
   logic [4:0] sec_address;
   logic [7:0] sec_dataIn;
   logic [3:0] sprite_count;
   logic       sprite_zero_next;
   logic       sprite_overflow;

   logic [7:0] oam [256];
   logic [7:0] sec [32];
   logic [7:0] exp_sec [32];
   logic       sec_wipe;
   int         wr_count;
   int         wr_snap;
   int         compared;
   int         mismatched;

   sprite_evaluator dut (
      .clock            (clock),
      .reset            (reset),
      .clock_EN         (clock_EN),
      .render_EN        (render_EN),
      .sprite_size_16   (sprite_size_16),
      .scanline         (scanline),
      .dot              (dot),
      .oam_address      (oam_address),
      .oam_data         (oam_data),
      .sec_write        (sec_write),
      .sec_address      (sec_address),
      .sec_dataIn       (sec_dataIn),
      .sprite_count     (sprite_count),
      .sprite_zero_next (sprite_zero_next),
      .sprite_overflow  (sprite_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign oam_data = oam[oam_address];

   always @(posedge clock) begin
      if (sec_wipe) begin
         for (int i = 0; i < 32; i++) sec[i] <= 8'h00;
      end else if (clock_EN && sec_write) begin
         sec[sec_address] <= sec_dataIn;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic en);
      clock_EN = en;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic run_dots(input logic [8:0] line, input int first, input int last, input bit slow);
      for (int d = first; d <= last; d++) begin
         scanline = line;
         dot      = 9'(d);
         if (slow) begin
            tick(1'b0);
            tick(1'b0);
         end
         tick(1'b1);
      end
   endtask

   // Every sprite i gets bytes {y, 10+i, 20+i, 30+i}.
   task automatic load_oam(input logic [7:0] y);
      for (int i = 0; i < 64; i++) begin
         oam[i*4]   = y;
         oam[i*4+1] = 8'(8'h10 + i);
         oam[i*4+2] = 8'(8'h20 + i);
         oam[i*4+3] = 8'(8'h30 + i);
      end
   endtask

   task automatic wipe_sec();
      sec_wipe = 1'b1;
      tick(1'b0);
      sec_wipe = 1'b0;
   endtask

   task automatic exp_clear();
      for (int i = 0; i < 32; i++) exp_sec[i] = 8'hFF;
   endtask

   task automatic exp_sprite(input int slot, input int idx, input logic [7:0] y);
      exp_sec[slot*4]   = y;
      exp_sec[slot*4+1] = 8'(8'h10 + idx);
      exp_sec[slot*4+2] = 8'(8'h20 + idx);
      exp_sec[slot*4+3] = 8'(8'h30 + idx);
   endtask

   task automatic check_sec(input string tag);
      for (int i = 0; i < 32; i++)
         check($sformatf("%s sec[%0d]", tag, i), {24'd0, sec[i]}, {24'd0, exp_sec[i]});
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      wr_count       = 0;
      sec_wipe       = 1'b0;
      reset          = 1'b1;
      clock_EN       = 1'b0;
      render_EN      = 1'b0;
      sprite_size_16 = 1'b0;
      scanline       = 9'd0;
      dot            = 9'd0;
      load_oam(8'hF8);
      wipe_sec();

      tick(1'b1);
      tick(1'b1);
      check("rst oam_address", {24'd0, oam_address}, 32'h0);
      check("rst sec_write", {31'd0, sec_write}, 32'h0);
      check("rst sec_address", {27'd0, sec_address}, 32'h0);
      check("rst sec_dataIn", {24'd0, sec_dataIn}, 32'h0);
      check("rst count", {28'd0, sprite_count}, 32'h0);
      check("rst zero", {31'd0, sprite_zero_next}, 32'h0);
      check("rst overflow", {31'd0, sprite_overflow}, 32'h0);
      reset     = 1'b0;
      render_EN = 1'b1;

      // Sprites 0..8 at 18,B0,B0,B8,B8,C0,C0,C8,C8; scanline B4, 8x8.
      load_oam(8'hF8);
      oam[0] = 8'h18; oam[1] = 8'hFF; oam[2] = 8'h23; oam[3] = 8'h58;
      oam[4]  = 8'hB0; oam[8]  = 8'hB0; oam[12] = 8'hB8; oam[16] = 8'hB8;
      oam[20] = 8'hC0; oam[24] = 8'hC0; oam[28] = 8'hC8; oam[32] = 8'hC8;
      run_dots(9'hB4, 0, 340, 1'b0);
      exp_clear();
      exp_sprite(0, 1, 8'hB0);
      exp_sprite(1, 2, 8'hB0);
      check_sec("line B4");
      check("line B4 count", {28'd0, sprite_count}, 32'd2);
      check("line B4 zero", {31'd0, sprite_zero_next}, 32'd0);
      check("line B4 overflow", {31'd0, sprite_overflow}, 32'd0);

      run_dots(9'h18, 0, 340, 1'b0);
      exp_clear();
      exp_sec[0] = 8'h18; exp_sec[1] = 8'hFF; exp_sec[2] = 8'h23; exp_sec[3] = 8'h58;
      check_sec("line 18");
      check("line 18 count", {28'd0, sprite_count}, 32'd1);
      check("line 18 zero", {31'd0, sprite_zero_next}, 32'd1);

      // Slow enable gives identical results; a disabled line writes nothing.
      wipe_sec();
      run_dots(9'hB4, 0, 340, 1'b1);
      exp_clear();
      exp_sprite(0, 1, 8'hB0);
      exp_sprite(1, 2, 8'hB0);
      check_sec("slow B4");
      check("slow B4 count", {28'd0, sprite_count}, 32'd2);
      check("slow B4 zero", {31'd0, sprite_zero_next}, 32'd0);
      render_EN = 1'b0;
      wr_snap   = wr_count;
      run_dots(9'hB5, 0, 340, 1'b1);
      check("disabled line writes", wr_count, wr_snap);
      check("disabled line count", {28'd0, sprite_count}, 32'd2);
      render_EN = 1'b1;

      // Ten sprites at Y=20 on scanline 22: eight copied, overflow raised.
      load_oam(8'hF8);
      for (int i = 0; i < 10; i++) oam[i*4] = 8'h20;
      run_dots(9'h22, 0, 340, 1'b0);
      exp_clear();
      for (int k = 0; k < 8; k++) exp_sprite(k, k, 8'h20);
      check_sec("ten sprites");
      check("ten count", {28'd0, sprite_count}, 32'd8);
      check("ten zero", {31'd0, sprite_zero_next}, 32'd1);
      check("ten overflow", {31'd0, sprite_overflow}, 32'd1);
      run_dots(9'd261, 0, 0, 1'b0);
      check("pre dot0 overflow", {31'd0, sprite_overflow}, 32'd1);
      run_dots(9'd261, 1, 1, 1'b0);
      check("pre dot1 overflow", {31'd0, sprite_overflow}, 32'd0);

      // Height boundaries.
      load_oam(8'hF8);
      oam[0] = 8'h10;
      sprite_size_16 = 1'b1;
      run_dots(9'h1F, 0, 340, 1'b0);
      check("8x16 line 1F count", {28'd0, sprite_count}, 32'd1);
      check("8x16 line 1F zero", {31'd0, sprite_zero_next}, 32'd1);
      run_dots(9'h20, 0, 340, 1'b0);
      check("8x16 line 20 count", {28'd0, sprite_count}, 32'd0);
      sprite_size_16 = 1'b0;
      run_dots(9'h17, 0, 340, 1'b0);
      check("8x8 line 17 count", {28'd0, sprite_count}, 32'd1);
      run_dots(9'h18, 0, 340, 1'b0);
      check("8x8 line 18 count", {28'd0, sprite_count}, 32'd0);
      oam[0] = 8'hF8;
      sprite_size_16 = 1'b1;
      run_dots(9'hEF, 0, 340, 1'b0);
      check("Y F8 line EF count", {28'd0, sprite_count}, 32'd0);
      sprite_size_16 = 1'b0;

      // Sprites 30..39 at Y=20: sprite 31 is mid-copy (m=1) at dot 100.
      load_oam(8'hF8);
      for (int i = 30; i < 40; i++) oam[i*4] = 8'h20;
      run_dots(9'h22, 0, 99, 1'b0);
      scanline = 9'h22;
      dot      = 9'd100;
      clock_EN = 1'b1;
      #1;
      check("copy sec_write", {31'd0, sec_write}, 32'd1);
      check("copy sec_address", {27'd0, sec_address}, 32'd5);
      check("copy oam_address", {24'd0, oam_address}, 32'h7D);
      check("copy count", {28'd0, sprite_count}, 32'd1);
      reset = 1'b1;
      tick(1'b1);
      check("mid rst oam_address", {24'd0, oam_address}, 32'h0);
      check("mid rst sec_write", {31'd0, sec_write}, 32'h0);
      check("mid rst sec_address", {27'd0, sec_address}, 32'h0);
      check("mid rst sec_dataIn", {24'd0, sec_dataIn}, 32'h0);
      check("mid rst count", {28'd0, sprite_count}, 32'h0);
      check("mid rst zero", {31'd0, sprite_zero_next}, 32'h0);
      reset   = 1'b0;
      wr_snap = wr_count;
      run_dots(9'h22, 101, 340, 1'b0);
      check("post rst writes", wr_count, wr_snap);
      check("post rst count", {28'd0, sprite_count}, 32'd0);
      run_dots(9'h22, 0, 340, 1'b0);
      check("recover count", {28'd0, sprite_count}, 32'd8);
      check("recover overflow", {31'd0, sprite_overflow}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sprite_evaluator.md
# sprite_evaluator

Per-scanline sprite evaluation stage of the PPU. It sits between the primary object attribute memory (256 bytes, combinational read port) and the secondary object attribute memory (32 bytes). For each visible scanline it clears secondary OAM, scans the 64 primary sprites for Y-range hits against the current scanline, and copies up to 8 hits into secondary OAM. It also produces the sprite-overflow and sprite-zero-next flags consumed by the status register and the sprite renderer.

## Interface
Parameters:
- `VISIBLE_LINES`, default 240: scanlines 0..VISIBLE_LINES-1 are evaluated.
- `PRERENDER_LINE`, default 261: scanline on which the overflow flag is cleared.

Ports:
- `clock` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `clock_EN` input 1: PPU dot enable; all state advances only on edges where `clock_EN`=1.
- `render_EN` input 1: background or sprite rendering enabled.
- `sprite_size_16` input 1: 1 selects 8x16 sprites (height 16), 0 selects 8x8 (height 8).
- `scanline` input 9: current scanline, 0..261.
- `dot` input 9: current dot, 0..340.
- `oam_address` output 8: primary OAM read address.
- `oam_data` input 8: primary OAM read data, combinational from `oam_address`.
- `sec_write` output 1: secondary OAM write strobe.
- `sec_address` output 5: secondary OAM address.
- `sec_dataIn` output 8: secondary OAM write data.
- `sprite_count` output 4: number of sprites copied for the next line, 0..8.
- `sprite_zero_next` output 1: sprite 0 was copied for the next line.
- `sprite_overflow` output 1: a ninth in-range sprite was found.

## Operation
- States: IDLE, CLEAR, EVAL_Y, COPY, FULL_SCAN, DONE.
- Registers:
  - `n`: 6-bit sprite index.
  - `m`: 2-bit byte index.
  - `count`: 4-bit.
  - `sprite_zero_next`.
  - `sprite_overflow`.
- Active line: `render_EN`=1 and `scanline` < VISIBLE_LINES. On other lines the block stays in IDLE with `sec_write`=0.
- Dot 0 of an active line: go to CLEAR.
- Dots 1..32 (CLEAR): `sec_write`=1, `sec_address`=dot-1, `sec_dataIn`=8'hFF.
- Dots 33..64: idle, `sec_write`=0.
- Dot 64 tick: set `n`=0, `m`=0, `count`=0, `sprite_zero_next`=0, then enter EVAL_Y.
- EVAL_Y:
  - `oam_address`={n,2'b00}.
  - diff = {1'b0,scanline} - {2'b00,oam_data}, computed 10-bit.
  - In range if diff[9]=0 and diff < height.
  - In range: `sec_write`=1, `sec_address`={count[2:0],2'b00}, `sec_dataIn`=oam_data. If n=0, set `sprite_zero_next`. Go to COPY with m=1.
  - Not in range: n=n+1. If n was 63, go to DONE.
- COPY:
  - `oam_address`={n,m}, `sec_write`=1, `sec_address`={count[2:0],m}, `sec_dataIn`=oam_data.
  - m=m+1.
  - On m=3: count=count+1 and n=n+1. Next state is FULL_SCAN if count becomes 8, DONE if n was 63, otherwise EVAL_Y.
- FULL_SCAN:
  - `oam_address`={n,2'b00}, `sec_write`=0.
  - In range: set `sprite_overflow`, go to DONE.
  - Otherwise n=n+1; n=63 with no hit goes to DONE.
  - The overflow check is exact; the hardware diagonal-scan bug is not modelled.
- DONE: `sec_write`=0, hold until dot 0 of the next line.
- Dot 257 tick: any state other than IDLE is forced to DONE. An evaluation in progress is truncated; bytes already written stay.
- `sprite_overflow` is cleared on the dot 1 tick of PRERENDER_LINE regardless of `render_EN`. It is otherwise sticky.
- `render_EN` falling mid-line: return to IDLE on the next enabled tick. `count` and the flags hold.

## Timing
- `oam_address`, `sec_write`, `sec_address` and `sec_dataIn` are combinational from registered state plus `oam_data`.
- Both OAMs sample on the same `clock` edge with `clock_EN`=1, so there is zero added latency: 1 tick per Y test and 4 ticks per copied sprite.
- `clock_EN`=0: no state change. `sec_write` is still driven, but the OAM ignores it.
- Reset values:
  - state IDLE; n=0, m=0, count=0.
  - `oam_address`=0, `sec_write`=0, `sec_address`=0, `sec_dataIn`=0.
  - `sprite_count`=0, `sprite_zero_next`=0, `sprite_overflow`=0.
  - Reset overrides `clock_EN`.
  - A reset mid-line leaves the block in IDLE until the next dot 0.
- `sprite_count` and `sprite_zero_next` are updated as evaluation proceeds and are final from the dot 257 tick until the next dot 64 tick.
- Worst case: 64 Y tests, or 8 copies (32 ticks) plus 56 Y tests, both fit within dots 65..256 (192 ticks).

## Test plan
- Default OAM, with sprites 0..8 at Y=18,B0,B0,B8,B8,C0,C0,C8,C8 and the rest at F8. On scanline 180 (B4), 8x8: sprites 1,2 copied to sec[0..7], count=2, zero_next=0, sec[8..31]=FF.
- Same OAM, scanline 0x18: sprite 0 copied with bytes 18,FF,23,58, zero_next=1, count=1.
- Ten sprites all at Y=0x20 on scanline 0x22: count=8, the first 8 are copied in index order, overflow=1. Overflow is cleared at scanline 261 dot 1.
- 8x16 with Y=0x10: scanline 0x1F hits; 0x20 misses. Same Y in 8x8: scanline 0x17 hits, 0x18 misses. Y=F8 never hits any line.
- `reset` asserted at dot 100 while in COPY: all outputs go to 0 on the next edge, and no writes occur until the next dot 0.
- `clock_EN` toggled 1-of-3 and `render_EN`=0 on one line: results are identical to continuous enable, and the disabled line produces no `sec_write`.
